// File: rtl/branch_pkg.sv
// Shared branch definitions: funct3 branch encodings and saturating-counter state constants.
`default_nettype none

package branch_pkg;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } funct3_e;

   localparam logic [1:0] c_CTR2_STRONG_NT = 2'd0;
   localparam logic [1:0] c_CTR2_WEAK_NT   = 2'd1;
   localparam logic [1:0] c_CTR2_WEAK_T    = 2'd2;
   localparam logic [1:0] c_CTR2_STRONG_T  = 2'd3;

   // Counter states for an arbitrary counter width (2-bit values above are the bits=2 case).
   function automatic int ctr_strong_nt(input int bits);
      return 0;
   endfunction

   function automatic int ctr_weak_nt(input int bits);
      return (1 << (bits - 1)) - 1;
   endfunction

   function automatic int ctr_weak_t(input int bits);
      return 1 << (bits - 1);
   endfunction

   function automatic int ctr_strong_t(input int bits);
      return (1 << bits) - 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup / execute-resolve bus of the branch predict unit.
`default_nettype none

interface branch_predict_unit_if #(
   parameter int XLEN = 32
);
   logic            LookupValid;
   logic [XLEN-1:0] LookupPC;
   logic            PredValid;
   logic            PredTaken;
   logic            ResValid;
   logic [XLEN-1:0] ResPC;
   logic [2:0]      ResFunct3;
   logic [XLEN-1:0] ResA;
   logic [XLEN-1:0] ResB;
   logic            ResPredTaken;
   logic            ResDone;
   logic            Diverge;
   logic            Mispredict;
   logic            ResIllegal;
   logic [31:0]     StatBranches;
   logic [31:0]     StatMispredicts;

   modport master (
      output LookupValid, LookupPC, ResValid, ResPC, ResFunct3, ResA, ResB, ResPredTaken,
      input  PredValid, PredTaken, ResDone, Diverge, Mispredict, ResIllegal,
             StatBranches, StatMispredicts
   );

   modport slave (
      input  LookupValid, LookupPC, ResValid, ResPC, ResFunct3, ResA, ResB, ResPredTaken,
      output PredValid, PredTaken, ResDone, Diverge, Mispredict, ResIllegal,
             StatBranches, StatMispredicts
   );
endinterface

`default_nettype wire

// File: rtl/branch_compare.sv
// Combinational branch condition evaluation; non-branch funct3 encodings flag Illegal.
`default_nettype none

module branch_compare
   import branch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  wire logic [2:0]      i_funct3,
   input  wire logic [XLEN-1:0] i_a,
   input  wire logic [XLEN-1:0] i_b,
   output logic                 o_taken,
   output logic                 o_illegal
);

   always_comb begin
      o_taken   = 1'b0;
      o_illegal = 1'b0;
      case (i_funct3)
         F3_BEQ:  o_taken = (i_a == i_b);
         F3_BNE:  o_taken = (i_a != i_b);
         F3_BLT:  o_taken = ($signed(i_a) <  $signed(i_b));
         F3_BGE:  o_taken = ($signed(i_a) >= $signed(i_b));
         F3_BLTU: o_taken = (i_a <  i_b);
         F3_BGEU: o_taken = (i_a >= i_b);
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor with in-unit resolve; optional perf counters under BRANCH_STATS_EN.
`default_nettype none

module branch_predict_unit
   import branch_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CTR_BITS    = 2
) (
   input wire logic             Clock,
   input wire logic             Reset,
   branch_predict_unit_if.slave bus
);

   localparam int                  c_IDXW     = $clog2(BHT_ENTRIES);
   localparam logic [CTR_BITS-1:0] c_CTR_INIT = CTR_BITS'(ctr_weak_nt(CTR_BITS));
   localparam logic [CTR_BITS-1:0] c_CTR_MAX  = CTR_BITS'(ctr_strong_t(CTR_BITS));
   localparam logic [CTR_BITS-1:0] c_CTR_MIN  = CTR_BITS'(ctr_strong_nt(CTR_BITS));

   logic [CTR_BITS-1:0] r_bht [BHT_ENTRIES];

   logic [c_IDXW-1:0]   w_lidx;
   logic [c_IDXW-1:0]   w_ridx;
   logic                w_taken;
   logic                w_illegal;
   logic                w_upd;
   logic                w_mis;
   logic [CTR_BITS-1:0] w_ctr_cur;
   logic [CTR_BITS-1:0] w_ctr_nxt;

   logic r_pred_valid;
   logic r_pred_taken;
   logic r_res_done;
   logic r_diverge;
   logic r_mispredict;
   logic r_illegal;

   assign w_lidx    = bus.LookupPC[c_IDXW+1:2];
   assign w_ridx    = bus.ResPC[c_IDXW+1:2];
   assign w_ctr_cur = r_bht[w_ridx];
   assign w_upd     = bus.ResValid & ~w_illegal;
   assign w_mis     = w_upd & (w_taken != bus.ResPredTaken);

   branch_compare #(
      .XLEN (XLEN)
   ) u_compare (
      .i_funct3  (bus.ResFunct3),
      .i_a       (bus.ResA),
      .i_b       (bus.ResB),
      .o_taken   (w_taken),
      .o_illegal (w_illegal)
   );

   always_comb begin
      w_ctr_nxt = w_ctr_cur;
      if (w_taken) begin
         if (w_ctr_cur != c_CTR_MAX) w_ctr_nxt = w_ctr_cur + CTR_BITS'(1);
      end else begin
         if (w_ctr_cur != c_CTR_MIN) w_ctr_nxt = w_ctr_cur - CTR_BITS'(1);
      end
   end

   // Lookup reads the table before this edge's update lands, giving read-before-write on index clashes.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= c_CTR_INIT;
      end else if (w_upd) begin
         r_bht[w_ridx] <= w_ctr_nxt;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
         r_res_done   <= 1'b0;
         r_diverge    <= 1'b0;
         r_mispredict <= 1'b0;
         r_illegal    <= 1'b0;
      end else begin
         r_pred_valid <= bus.LookupValid;
         r_pred_taken <= bus.LookupValid & r_bht[w_lidx][CTR_BITS-1];
         r_res_done   <= bus.ResValid;
         r_diverge    <= w_upd & w_taken;
         r_mispredict <= w_mis;
         r_illegal    <= bus.ResValid & w_illegal;
      end
   end

   assign bus.PredValid  = r_pred_valid;
   assign bus.PredTaken  = r_pred_taken;
   assign bus.ResDone    = r_res_done;
   assign bus.Diverge    = r_diverge;
   assign bus.Mispredict = r_mispredict;
   assign bus.ResIllegal = r_illegal;

`ifdef BRANCH_STATS_EN
   logic [31:0] r_stat_br;
   logic [31:0] r_stat_mis;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_stat_br  <= '0;
         r_stat_mis <= '0;
      end else begin
         if (w_upd && (r_stat_br != 32'hFFFF_FFFF))  r_stat_br  <= r_stat_br + 32'd1;
         if (w_mis && (r_stat_mis != 32'hFFFF_FFFF)) r_stat_mis <= r_stat_mis + 32'd1;
      end
   end

   assign bus.StatBranches    = r_stat_br;
   assign bus.StatMispredicts = r_stat_mis;
`else
   assign bus.StatBranches    = 32'd0;
   assign bus.StatMispredicts = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit; stat expectations follow BRANCH_STATS_EN.
`default_nettype none

module tb_branch_predict_unit;
   import branch_pkg::*;

   logic Clock;
   logic Reset;
   int   n_checks;
   int   n_errors;
   logic [31:0] exp_br;
   logic [31:0] exp_mis;

   branch_predict_unit_if #(.XLEN(32)) bus ();

   branch_predict_unit #(
      .XLEN        (32),
      .BHT_ENTRIES (64),
      .CTR_BITS    (2)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle();
      bus.LookupValid  = 1'b0;
      bus.LookupPC     = '0;
      bus.ResValid     = 1'b0;
      bus.ResPC        = '0;
      bus.ResFunct3    = 3'b000;
      bus.ResA         = '0;
      bus.ResB         = '0;
      bus.ResPredTaken = 1'b0;
   endtask

   task automatic drive_res(input logic [31:0] pc, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b, input logic pt);
      bus.ResValid     = 1'b1;
      bus.ResPC        = pc;
      bus.ResFunct3    = f3;
      bus.ResA         = a;
      bus.ResB         = b;
      bus.ResPredTaken = pt;
   endtask

   task automatic note_stats(input logic legal, input logic mis);
`ifdef BRANCH_STATS_EN
      if (legal) exp_br  = exp_br + 32'd1;
      if (mis)   exp_mis = exp_mis + 32'd1;
`endif
   endtask

   task automatic res_step(input string tag, input logic [31:0] pc, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b, input logic pt,
                           input logic e_div, input logic e_mis, input logic e_ill);
      drive_res(pc, f3, a, b, pt);
      tick();
      idle();
      note_stats(!e_ill, e_mis);
      chk({tag, "_done"}, 32'(bus.ResDone), 32'd1);
      chk({tag, "_div"},  32'(bus.Diverge), 32'(e_div));
      chk({tag, "_mis"},  32'(bus.Mispredict), 32'(e_mis));
      chk({tag, "_ill"},  32'(bus.ResIllegal), 32'(e_ill));
      chk({tag, "_sbr"},  bus.StatBranches, exp_br);
      chk({tag, "_smis"}, bus.StatMispredicts, exp_mis);
   endtask

   task automatic lookup_step(input string tag, input logic [31:0] pc, input logic e_taken);
      bus.LookupValid = 1'b1;
      bus.LookupPC    = pc;
      tick();
      idle();
      chk({tag, "_pv"}, 32'(bus.PredValid), 32'd1);
      chk({tag, "_pt"}, 32'(bus.PredTaken), 32'(e_taken));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      exp_br   = '0;
      exp_mis  = '0;
      Reset    = 1'b1;
      idle();
      repeat (2) @(posedge Clock);
      #1;
      chk("rst_pv",   32'(bus.PredValid), 32'd0);
      chk("rst_pt",   32'(bus.PredTaken), 32'd0);
      chk("rst_done", 32'(bus.ResDone), 32'd0);
      chk("rst_div",  32'(bus.Diverge), 32'd0);
      chk("rst_mis",  32'(bus.Mispredict), 32'd0);
      chk("rst_ill",  32'(bus.ResIllegal), 32'd0);
      chk("rst_sbr",  bus.StatBranches, 32'd0);
      chk("rst_smis", bus.StatMispredicts, 32'd0);
      Reset = 1'b0;
      tick();

      // Fresh table is weakly-not-taken everywhere.
      lookup_step("lk_init", 32'h100, 1'b0);
      tick();
      chk("idle_pv",   32'(bus.PredValid), 32'd0);
      chk("idle_done", 32'(bus.ResDone), 32'd0);
      chk("idle_div",  32'(bus.Diverge), 32'd0);

      // Index 0: 1 -> 2 -> 3, saturate at 3, then walk down.
      res_step("beq1", 32'h100, F3_BEQ, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      res_step("beq2", 32'h100, F3_BEQ, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      lookup_step("lk_c3", 32'h100, 1'b1);
      res_step("beq3", 32'h100, F3_BEQ, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      res_step("beqn1", 32'h100, F3_BEQ, 32'd5, 32'd6, 1'b1, 1'b0, 1'b1, 1'b0);
      lookup_step("lk_sat", 32'h100, 1'b1);
      res_step("beqn2", 32'h100, F3_BEQ, 32'd5, 32'd6, 1'b1, 1'b0, 1'b1, 1'b0);
      lookup_step("lk_c1", 32'h100, 1'b0);

      // Signed versus unsigned comparisons on index 1.
      res_step("blt",  32'h104, F3_BLT,  32'hF000FFFF, 32'hF, 1'b0, 1'b1, 1'b1, 1'b0);
      res_step("bltu", 32'h104, F3_BLTU, 32'hF000FFFF, 32'hF, 1'b0, 1'b0, 1'b0, 1'b0);
      res_step("bgeu", 32'h104, F3_BGEU, 32'hF000FFFF, 32'hF, 1'b0, 1'b1, 1'b1, 1'b0);
      res_step("bge",  32'h104, F3_BGE,  32'hF000FFFF, 32'hF, 1'b0, 1'b0, 1'b0, 1'b0);

      res_step("bne", 32'h108, F3_BNE, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);

      // Same-cycle lookup and taken resolve at index 16 (counter 1): lookup sees old value.
      bus.LookupValid = 1'b1;
      bus.LookupPC    = 32'h40;
      drive_res(32'h40, F3_BEQ, 32'd7, 32'd7, 1'b0);
      tick();
      idle();
      note_stats(1'b1, 1'b1);
      chk("rbw_pv",  32'(bus.PredValid), 32'd1);
      chk("rbw_pt",  32'(bus.PredTaken), 32'd0);
      chk("rbw_div", 32'(bus.Diverge), 32'd1);
      chk("rbw_mis", 32'(bus.Mispredict), 32'd1);
      chk("rbw_smis", bus.StatMispredicts, exp_mis);
      lookup_step("lk_rbw", 32'h40, 1'b1);

      // Illegal encodings leave the counter (now 2) and statistics alone.
      res_step("ill010", 32'h40, 3'b010, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      res_step("ill011", 32'h40, 3'b011, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      lookup_step("lk_ill", 32'h40, 1'b1);

      // Reset mid-stream must clear outputs without waiting for a clock edge.
      bus.LookupValid = 1'b1;
      bus.LookupPC    = 32'h40;
      drive_res(32'h40, F3_BEQ, 32'd1, 32'd1, 1'b0);
      tick();
      chk("pre_rst_done", 32'(bus.ResDone), 32'd1);
      #2;
      Reset = 1'b1;
      #1;
      chk("mrst_pv",   32'(bus.PredValid), 32'd0);
      chk("mrst_pt",   32'(bus.PredTaken), 32'd0);
      chk("mrst_done", 32'(bus.ResDone), 32'd0);
      chk("mrst_div",  32'(bus.Diverge), 32'd0);
      chk("mrst_mis",  32'(bus.Mispredict), 32'd0);
      chk("mrst_ill",  32'(bus.ResIllegal), 32'd0);
      chk("mrst_sbr",  bus.StatBranches, 32'd0);
      chk("mrst_smis", bus.StatMispredicts, 32'd0);
      exp_br  = '0;
      exp_mis = '0;
      idle();
      tick();
      Reset = 1'b0;
      tick();
      lookup_step("lk_post_rst", 32'h40, 1'b0);
      chk("post_rst_done", 32'(bus.ResDone), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and PC width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 64, prediction table depth; power of two, 2 to 1024.
REQ-003 SHALL have parameter CTR_BITS, default 2, saturating counter width; 2 to 4.
REQ-004 SHALL have port Clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port LookupValid  in  1  fetch-stage prediction request.
REQ-007 SHALL have port LookupPC  in  XLEN  fetch PC.
REQ-008 SHALL have port PredValid  out  1  registered; prediction is valid.
REQ-009 SHALL have port PredTaken  out  1  registered; predicted direction.
REQ-010 SHALL have port ResValid  in  1  execute-stage branch resolution request.
REQ-011 SHALL have port ResPC  in  XLEN  branch PC.
REQ-012 SHALL have port ResFunct3  in  3  branch funct3 (BEQ/BNE/BLT/BGE/BLTU/BGEU).
REQ-013 SHALL have port ResA, ResB  in  XLEN  rs1/rs2 operands.
REQ-014 SHALL have port ResPredTaken  in  1  prediction carried down the pipeline for this branch.
REQ-015 SHALL have port ResDone  out  1  registered; resolution result is valid.
REQ-016 SHALL have port Diverge  out  1  registered; branch actually taken.
REQ-017 SHALL have port Mispredict  out  1  registered; Diverge differs from ResPredTaken.
REQ-018 SHALL have port ResIllegal  out  1  registered; funct3 is not a branch encoding.
REQ-019 SHALL have port StatBranches, StatMispredicts  out  32 each  performance counters.

Function
REQ-020 SHALL compute table index as PC[$clog2(BHT_ENTRIES)+1:2] for both lookup and resolve.
REQ-021 SHALL assert PredValid one cycle after LookupValid, and otherwise deassert it.
REQ-022 SHALL drive PredTaken equal to the MSB of the indexed counter, sampled at the lookup edge.
REQ-023 SHALL assert ResDone exactly one cycle after ResValid, with Diverge, Mispredict and ResIllegal valid in that cycle.
REQ-024 SHALL evaluate BEQ (A==B), BNE (A!=B), BLT/BGE (signed), and BLTU/BGEU (unsigned) across the full XLEN.
REQ-025 SHALL, for funct3 010 or 011: set ResIllegal=1, Diverge=0 and Mispredict=0, and leave the table and statistics unchanged.
REQ-026 SHALL, on a legal resolve, increment the indexed counter when the branch is taken and decrement it when not taken, saturating at 0 and 2^CTR_BITS-1 (no wrap).
REQ-027 SHALL, when lookup and resolve target the same index in the same cycle, return the pre-update counter value (read-before-write).
REQ-028 SHALL accept lookup and resolve every cycle back-to-back, with no stall and no ready signal.
REQ-029 SHALL, while ResValid=0, hold Diverge, Mispredict and ResIllegal at 0.

Reset
REQ-030 SHALL, on Reset assertion, immediately clear PredValid, PredTaken, ResDone, Diverge, Mispredict, ResIllegal and both Stat outputs to 0.
REQ-031 SHALL initialise every counter to weakly-not-taken, 2^(CTR_BITS-1)-1, and discard any in-flight lookup or resolve.

Configuration
REQ-032 SHALL, when BRANCH_STATS_EN is defined, increment StatBranches on every legal resolve and StatMispredicts on every Mispredict; both saturate at 32'hFFFFFFFF.
REQ-033 SHALL, when BRANCH_STATS_EN is undefined, tie both Stat outputs to 0 and synthesise no counter logic.

Structure
REQ-034 SHALL source funct3 branch encodings and the counter-state constants (strong/weak taken/not-taken) from the shared branch_pkg.
REQ-035 SHALL place comparison logic in a combinational sub-module branch_compare (inputs Funct3, A, B; outputs Taken, Illegal).

Verification
REQ-036 Bench SHALL cover: after reset, lookup PC=0x100 -> next cycle PredValid=1, PredTaken=0.
REQ-037 Bench SHALL cover: two resolves PC=0x100, BEQ, A=B=5 -> counter 3; lookup PC=0x100 -> PredTaken=1; a third taken resolve leaves the counter at 3.
REQ-038 Bench SHALL cover: BLT A=0xF000FFFF B=0xF -> Diverge=1; BLTU with the same operands -> Diverge=0; BGEU -> Diverge=1.
REQ-039 Bench SHALL cover: resolve BNE A=B=0 with ResPredTaken=1 -> Diverge=0, Mispredict=1; StatMispredicts increments by 1 with BRANCH_STATS_EN defined, and stays 0 without it.
REQ-040 Bench SHALL cover: same-cycle lookup and resolve at PC=0x40 with counter 1, taken -> PredTaken=0, then the next lookup returns PredTaken=1.
REQ-041 Bench SHALL cover: funct3=010 -> ResIllegal=1, counter unchanged; Reset asserted mid-stream -> all outputs 0 before the next clock edge.
